// File: rtl/freq_bcd_pkg.sv
// Shared types and constants for the frequency display binary-to-BCD path.
package freq_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int ACC_DIG     = 5;
  localparam int MAX_VAL_DEF = 9999;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bcd_add3_cell.sv
// One-digit shift-add-3 correction: digits above 4 get +3 before the left shift.
module bcd_add3_cell
  import freq_bcd_pkg::*;
(
  input  bcd_t d_i,
  output bcd_t d_o
);

  assign d_o = (d_i > 4'd4) ? (d_i + 4'd3) : d_i;

endmodule

// File: rtl/freq_bcd_sequencer.sv
// Sequential binary-to-BCD converter between gate-time counter and 7-segment scan driver.
// Build option FREQ_BCD_SATURATE_EN: pegs the displayed digits at 9999 on overflow.
//
// state | meaning
// IDLE  | ready for a sample, outputs hold the last result
// SHIFT | one shift-add-3 iteration per clock, MSB first
// DONE  | result presented, waiting for out_ready
module freq_bcd_sequencer
  import freq_bcd_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int OUT_DIG = 4,
  parameter int MAX_VAL = MAX_VAL_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] freq,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      thous,
  output logic [3:0]      hunds,
  output logic [3:0]      tens,
  output logic [3:0]      ones,
  output logic            ovf
);

  localparam int ACC_W = ACC_DIG * 4;
  localparam int OUT_W = OUT_DIG * 4;
  localparam int CNT_W = $clog2(IN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);
  localparam logic [31:0]      MAX_U    = 32'(MAX_VAL);

  state_e            state_q, state_d;
  logic [IN_W-1:0]   sh_q, sh_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_r_q, ovf_r_d;
  logic [OUT_W-1:0]  dig_q, dig_d;
  logic              ovf_q, ovf_d;

  logic [ACC_W-1:0]      acc_adj;
  logic [ACC_W+IN_W-1:0] cat_nxt;

  for (genvar g = 0; g < ACC_DIG; g++) begin : g_add3
    bcd_add3_cell u_cell (
      .d_i (acc_q[g*4 +: 4]),
      .d_o (acc_adj[g*4 +: 4])
    );
  end

  // Corrected accumulator and shift register move left together as one word.
  assign cat_nxt = {acc_adj, sh_q} << 1;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_r_d = ovf_r_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d    = freq;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_r_d = (32'(freq) > MAX_U);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = cat_nxt[ACC_W+IN_W-1:IN_W];
        sh_d  = cat_nxt[IN_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          ovf_d   = ovf_r_q;
`ifdef FREQ_BCD_SATURATE_EN
          dig_d   = ovf_r_q ? {OUT_DIG{4'd9}} : cat_nxt[IN_W+OUT_W-1:IN_W];
`else
          dig_d   = cat_nxt[IN_W+OUT_W-1:IN_W];
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_r_q <= 1'b0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_r_q <= ovf_r_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign thous     = dig_q[15:12];
  assign hunds     = dig_q[11:8];
  assign tens      = dig_q[7:4];
  assign ones      = dig_q[3:0];
  assign ovf       = ovf_q;

endmodule
